// File: rtl/fa_pkg.sv
// Shared types for the full-adder result packer: the packed word record and its reset value.
// FA_WIDTH sets the word width that the packer and its FIFO are built around.
package fa_pkg;

    localparam int FA_WIDTH = 8;
    localparam int FA_CNTW  = $clog2(FA_WIDTH + 1);

    typedef struct packed {
        logic [FA_WIDTH-1:0] data;
        logic                cout;
        logic [FA_CNTW-1:0]  bits;
    } fa_word_t;

    localparam fa_word_t FA_WORD_RST = '{data: '0, cout: 1'b0, bits: '0};

endpackage

// File: rtl/fa_word_fifo.sv
// Synchronous FIFO of packed words: push visible at head one cycle later, no bypass.
// Pop when empty is ignored; push when full succeeds only alongside a pop.
module fa_word_fifo
    import fa_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  logic     pop,
    input  fa_word_t din,
    output logic     full,
    output logic     empty,
    output fa_word_t head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    fa_word_t    mem [DEPTH];
    fa_word_t    hold;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // When empty the head shows the last word handed out, so outputs hold steady.
    assign head = empty ? hold : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold   <= FA_WORD_RST;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                hold   <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fa_result_packer.sv
// Packs the adder's sum-bit stream LSB-first into words and queues them; push-to-valid is one cycle.
// The adder cannot stall, so a word arriving at a full FIFO is dropped and flagged in sticky overflow.
module fa_result_packer
    import fa_pkg::*;
#(
    parameter  int WIDTH = FA_WIDTH,
    parameter  int DEPTH = 2,
    localparam int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             sum,
    input  logic             cout,
    input  logic             flush,
    input  logic             ovf_clr,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_data,
    output logic             word_cout,
    output logic [CNTW-1:0]  word_bits,
    output logic             overflow
);

    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CNTW-1:0]  bit_cnt;
    logic             last_cout;
    logic             push;
    logic             drop;
    logic             full;
    logic             empty;
    fa_word_t         push_word;
    fa_word_t         head;

    // The incoming bit is always folded in before a flush, so one push covers both.
    always_comb begin
        acc_nxt        = acc;
        push_word      = FA_WORD_RST;
        if (in_valid) begin
            acc_nxt = acc | (WIDTH'(sum) << bit_cnt);
        end
        push           = (in_valid && (bit_cnt == LAST)) ||
                         (flush && (in_valid || (bit_cnt != '0)));
        push_word.data = acc_nxt;
        push_word.cout = in_valid ? cout : last_cout;
        push_word.bits = in_valid ? (bit_cnt + CNTW'(1)) : bit_cnt;
    end

    // Full implies non-empty, so a pop this cycle is exactly word_ready.
    assign drop = push && full && !word_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            bit_cnt   <= '0;
            last_cout <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                acc     <= '0;
                bit_cnt <= '0;
            end else if (in_valid) begin
                acc     <= acc_nxt;
                bit_cnt <= bit_cnt + CNTW'(1);
            end
            if (in_valid) begin
                last_cout <= cout;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    fa_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (word_ready),
        .din     (push_word),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    assign word_valid = !empty;
    assign word_data  = head.data;
    assign word_cout  = head.cout;
    assign word_bits  = head.bits;

endmodule

// File: tb/tb_fa_result_packer.sv
// Directed bench for fa_result_packer: stimulus queues expected words, a negedge monitor checks them.
module tb_fa_result_packer;
    import fa_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNTW  = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             sum = 1'b0;
    logic             cout = 1'b0;
    logic             flush = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             word_ready = 1'b0;
    logic             word_valid;
    logic [WIDTH-1:0] word_data;
    logic             word_cout;
    logic [CNTW-1:0]  word_bits;
    logic             overflow;

    fa_word_t q[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fa_result_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .sum        (sum),
        .cout       (cout),
        .flush      (flush),
        .ovf_clr    (ovf_clr),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_cout  (word_cout),
        .word_bits  (word_bits),
        .overflow   (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic s, input logic c, input logic f);
        in_valid = v;
        sum      = s;
        cout     = c;
        flush    = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sum      = 1'b0;
        cout     = 1'b0;
        flush    = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input logic lc, input bit keep, input bit clr_last);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) ovf_clr = clr_last;
            cyc(1'b1, d[i], (i == 7) ? lc : 1'b0, 1'b0);
        end
        if (keep) q.push_back('{data: d, cout: lc, bits: 4'd8});
    endtask

    // Monitor: every presented head is compared with the oldest expected word.
    initial begin
        fa_word_t act;
        forever begin
            @(negedge clk);
            if (reset_n && word_valid) begin
                act = '{data: word_data, cout: word_cout, bits: word_bits};
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: got %0h, expected no word", act);
                end else begin
                    if (act !== q[0]) begin
                        fails++;
                        $display("FAIL %s: got %0h, expected %0h",
                                 word_ready ? "word" : "stall_hold", act, q[0]);
                    end
                    if (word_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        #3;
        check("rst_valid", word_valid, 0);
        check("rst_data", word_data, 0);
        check("rst_cout", word_cout, 0);
        check("rst_bits", word_bits, 0);
        check("rst_ovf", overflow, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        word_ready = 1'b1;

        // Full word, sum 1,0,1,1,0,0,1,0 -> 0x4D
        send_word(8'h4D, 1'b1, 1'b1, 1'b0);
        check("full_word_valid_t1", word_valid, 1);
        cyc(0, 0, 0, 0);
        check("full_word_one_cycle", word_valid, 0);

        // Partial flush
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 0);
        cyc(0, 0, 0, 1);
        q.push_back('{data: 8'h03, cout: 1'b1, bits: 4'd3});
        cyc(0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0);
        check("second_flush_empty", word_valid, 0);

        // Flush together with the completing bit
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 1);
        q.push_back('{data: 8'h80, cout: 1'b1, bits: 4'd8});
        repeat (3) cyc(0, 0, 0, 0);
        check("flush_coincident_single", word_valid, 0);

        // Backpressure and overflow; clear coinciding with the drop loses to the set
        word_ready = 1'b0;
        send_word(8'hA5, 1'b0, 1'b1, 1'b0);
        send_word(8'h3C, 1'b1, 1'b1, 1'b0);
        send_word(8'hFF, 1'b0, 1'b0, 1'b1);
        check("ovf_set_wins", overflow, 1);
        check("stalled_valid", word_valid, 1);
        repeat (4) cyc(0, 0, 0, 0);
        word_ready = 1'b1;
        repeat (3) cyc(0, 0, 0, 0);
        check("drained_valid", word_valid, 0);
        check("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        cyc(0, 0, 0, 0);
        check("ovf_clr", overflow, 0);

        // Full FIFO with a pop in the completing cycle
        word_ready = 1'b0;
        send_word(8'h12, 1'b0, 1'b1, 1'b0);
        send_word(8'h34, 1'b1, 1'b1, 1'b0);
        d = 8'h56;
        for (int i = 0; i < 7; i++) cyc(1, d[i], 0, 0);
        word_ready = 1'b1;
        cyc(1, d[7], 1, 0);
        q.push_back('{data: 8'h56, cout: 1'b1, bits: 4'd8});
        repeat (4) cyc(0, 0, 0, 0);
        check("full_pop_no_ovf", overflow, 0);
        check("full_pop_drained", word_valid, 0);

        // Asynchronous reset mid-word
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_data", word_data, 0);
        check("async_rst_valid", word_valid, 0);
        check("async_rst_bits", word_bits, 0);
        check("async_rst_cout", word_cout, 0);
        check("async_rst_ovf", overflow, 0);
        q.delete();
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(8'h9A, 1'b1, 1'b1, 1'b0);
        repeat (4) cyc(0, 0, 0, 0);

        for (int i = 0; i < 20 && q.size() != 0; i++) cyc(0, 0, 0, 0);
        check("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
